// File: rtl/pb_loader_pkg.sv
// pb_loader_pkg -- shared types and constants for the PicoBlaze code loader.
//
// Contents:
//   pb_loader_state_e : loader FSM state encoding
//   SYNC_BYTE_DEF     : default frame start marker
//   ADDR_W / DATA_W   : code RAM address and instruction widths
//   CODE_DEPTH        : code RAM depth in words
//   MAX_WORDS / CNT_W : largest legal word count and the counter width that holds it
//   B0_* / INSTR_*    : bit positions of the fields carried in word byte 0
//   count_legal()     : word-count range check
package pb_loader_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 18;
  localparam int CODE_DEPTH = 1024;
  localparam int MAX_WORDS  = CODE_DEPTH;
  localparam int CNT_W      = 11;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h5A;

  // Byte 0 of a word: [1:0] carry instr[17:16], [7:2] are reserved and must be 0.
  localparam int B0_RSVD_MSB  = 7;
  localparam int B0_RSVD_LSB  = 2;
  localparam int B0_INSTR_MSB = 1;
  localparam int INSTR_HI_LSB = 16;

  typedef enum logic [3:0] {
    ST_HOLD,
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_CNT_H,
    ST_CNT_L,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_WRITE,
    ST_CHK,
    ST_FAIL
  } pb_loader_state_e;

  // A frame must carry between 1 and MAX_WORDS words.
  function automatic logic count_legal(input logic [15:0] cnt);
    return (cnt != 16'd0) && (cnt <= 16'(MAX_WORDS));
  endfunction

endpackage

// File: rtl/pb_loader_timeout.sv
// pb_loader_timeout -- inter-byte watchdog for the code loader.
//
// A down-counter reloaded with TIMEOUT_CYCLES whenever clear_i is high and
// decremented on every enabled cycle. expired_o rises once TIMEOUT_CYCLES
// enabled cycles have elapsed since the last clear, so the idle gap that
// first aborts a frame is TIMEOUT_CYCLES+1 cycles long.
//
// Ports:
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   clear_i    : reload the counter (byte handshake, or not in a timed state)
//   en_i       : count this cycle
//   expired_o  : budget exhausted while enabled
module pb_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/pb_code_loader.sv
// pb_code_loader -- drives the LOAD (port B) side of the PicoBlaze code RAM.
//
// Receives a framed byte stream (SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, then
// CNT words of 3 bytes), assembles 18-bit instructions and writes them to
// consecutive code addresses while holding the KCPSM3 in reset.
//
// Build option: define PB_LOADER_CHECKSUM_EN to require a trailing CHK byte;
// the 8-bit sum of every byte from ADDR_H through CHK must then be 8'h00.
//
// Handshake: a byte is transferred on a rising CLK edge where RX_VALID and
// RX_READY are both high; RX_READY depends only on the FSM state, never on
// RX_VALID, and RX_DATA is only looked at in a handshake cycle.
//
// Ports:
//   CLK, RST_N        : clock (also the RAM LOAD_CLK), async active-low reset
//   RX_DATA/VALID/READY : host byte stream
//   LOAD_ADDRESS/INSTRUCTION/WE : code RAM write port
//   PB_RESET          : KCPSM3 reset, active high
//   BUSY, DONE, ERROR : frame in progress / load completed pulse / sticky error
//   WORDS_WRITTEN     : words written in the current or last frame
//   DBG_STATE         : current FSM state
module pb_code_loader
  import pb_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         HOLD_CYCLES    = 16,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [7:0]          RX_DATA,
  input  logic                RX_VALID,
  output logic                RX_READY,
  output logic [ADDR_W-1:0]   LOAD_ADDRESS,
  output logic [DATA_W-1:0]   LOAD_INSTRUCTION,
  output logic                LOAD_WE,
  output logic                PB_RESET,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERROR,
  output logic [CNT_W-1:0]    WORDS_WRITTEN,
  output pb_loader_state_e    DBG_STATE
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  pb_loader_state_e    state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [7:0]          cnt_hi_q, cnt_hi_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic                error_q, error_d;
  logic                done_q, done_d;
`ifdef PB_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic                hs;
  logic                timed;
  logic                to_expired;
  logic [15:0]         cnt_full;

  assign hs       = RX_VALID && RX_READY;
  assign cnt_full = {cnt_hi_q, RX_DATA};

  // The watchdog only runs between bytes of a frame; any other state keeps it reloaded.
  assign timed = (state_q == ST_ADDR_H) || (state_q == ST_ADDR_L) ||
                 (state_q == ST_CNT_H)  || (state_q == ST_CNT_L)  ||
                 (state_q == ST_W0)     || (state_q == ST_W1)     ||
                 (state_q == ST_W2)     || (state_q == ST_CHK);

  pb_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .clear_i  (hs || !timed),
    .en_i     (timed),
    .expired_o(to_expired)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    cnt_hi_d   = cnt_hi_q;
    rem_d      = rem_q;
    words_d    = words_q;
    error_d    = error_q;
    done_d     = 1'b0;
`ifdef PB_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    RX_READY   = 1'b0;
    LOAD_WE    = 1'b0;
    BUSY       = 1'b0;
    PB_RESET   = 1'b1;

    case (state_q)
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end
      ST_IDLE: begin
        RX_READY = 1'b1;
        // After a failed frame the CPU stays in reset until a good load.
        PB_RESET = error_q;
        if (hs && (RX_DATA == SYNC_BYTE)) begin
          state_d = ST_ADDR_H;
          error_d = 1'b0;
          words_d = '0;
`ifdef PB_LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
        end
      end
      ST_ADDR_H: begin
        RX_READY = 1'b1;
        BUSY     = 1'b1;
        if (hs) begin
          addr_d  = {RX_DATA[1:0], addr_q[7:0]};
          state_d = ST_ADDR_L;
        end else if (to_expired) begin
          state_d = ST_FAIL;
        end
      end
      ST_ADDR_L: begin
        RX_READY = 1'b1;
        BUSY     = 1'b1;
        if (hs) begin
          addr_d  = {addr_q[9:8], RX_DATA};
          state_d = ST_CNT_H;
        end else if (to_expired) begin
          state_d = ST_FAIL;
        end
      end
      ST_CNT_H: begin
        RX_READY = 1'b1;
        BUSY     = 1'b1;
        if (hs) begin
          cnt_hi_d = RX_DATA;
          state_d  = ST_CNT_L;
        end else if (to_expired) begin
          state_d = ST_FAIL;
        end
      end
      ST_CNT_L: begin
        RX_READY = 1'b1;
        BUSY     = 1'b1;
        if (hs) begin
          if (count_legal(cnt_full)) begin
            rem_d   = cnt_full[CNT_W-1:0];
            state_d = ST_W0;
          end else begin
            state_d = ST_FAIL;
          end
        end else if (to_expired) begin
          state_d = ST_FAIL;
        end
      end
      ST_W0: begin
        RX_READY = 1'b1;
        BUSY     = 1'b1;
        if (hs) begin
          if (RX_DATA[B0_RSVD_MSB:B0_RSVD_LSB] != '0) begin
            state_d = ST_FAIL;
          end else begin
            instr_d = {RX_DATA[B0_INSTR_MSB:0], instr_q[INSTR_HI_LSB-1:0]};
            state_d = ST_W1;
          end
        end else if (to_expired) begin
          state_d = ST_FAIL;
        end
      end
      ST_W1: begin
        RX_READY = 1'b1;
        BUSY     = 1'b1;
        if (hs) begin
          instr_d = {instr_q[17:16], RX_DATA, instr_q[7:0]};
          state_d = ST_W2;
        end else if (to_expired) begin
          state_d = ST_FAIL;
        end
      end
      ST_W2: begin
        RX_READY = 1'b1;
        BUSY     = 1'b1;
        if (hs) begin
          instr_d = {instr_q[17:8], RX_DATA};
          state_d = ST_WRITE;
        end else if (to_expired) begin
          state_d = ST_FAIL;
        end
      end
      ST_WRITE: begin
        BUSY    = 1'b1;
        LOAD_WE = 1'b1;
        // Address is a 10-bit counter, so 1023 rolls over to 0 naturally.
        addr_d  = addr_q + ADDR_W'(1);
        words_d = words_q + CNT_W'(1);
        rem_d   = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
`ifdef PB_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_HOLD;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = ST_W0;
        end
      end
`ifdef PB_LOADER_CHECKSUM_EN
      ST_CHK: begin
        RX_READY = 1'b1;
        BUSY     = 1'b1;
        if (hs) begin
          if ((sum_q + RX_DATA) == 8'h00) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FAIL;
          end
        end else if (to_expired) begin
          state_d = ST_FAIL;
        end
      end
`endif
      ST_FAIL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase

`ifdef PB_LOADER_CHECKSUM_EN
    // Running sum over every frame byte after SYNC (the CHK byte itself is
    // checked above against sum_q + RX_DATA).
    if (hs && timed) begin
      sum_d = sum_q + RX_DATA;
    end
`endif

    // ERROR is visible from the FAIL cycle onward.
    if (state_d == ST_FAIL) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      addr_q     <= '0;
      instr_q    <= '0;
      cnt_hi_q   <= '0;
      rem_q      <= '0;
      words_q    <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
`ifdef PB_LOADER_CHECKSUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      cnt_hi_q   <= cnt_hi_d;
      rem_q      <= rem_d;
      words_q    <= words_d;
      error_q    <= error_d;
      done_q     <= done_d;
`ifdef PB_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign LOAD_ADDRESS     = addr_q;
  assign LOAD_INSTRUCTION = instr_q;
  assign DONE             = done_q;
  assign ERROR            = error_q;
  assign WORDS_WRITTEN    = words_q;
  assign DBG_STATE        = state_q;

endmodule
